// File: rtl/ctrl_dispatch.sv
// Change-detecting control dispatcher: FIFO of changed words, offered one at a time with HOLD idle cycles after each.
// Push-to-offer latency 2 edges; out_ready low stalls in PRESENT; a full FIFO blocks the change and sets sticky overflow.
module ctrl_dispatch #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               ctrl_in,
  input  logic                     ctrl_valid,
  input  logic                     out_ready,
  input  logic                     clear_ovf,
  output logic                     out_valid,
  output logic [7:0]               out_word,
  output logic [7:0]               applied_word,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
  localparam logic [3:0]    HOLD_CNT = 4'(HOLD);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [7:0]      last_word_q, last_word_d;
  logic [7:0]      out_word_q, out_word_d;
  logic [7:0]      applied_q, applied_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic            ovf_q, ovf_d;
  logic            push_req, full, pop, push, blocked, accept;

  assign push_req = ctrl_valid && (ctrl_in != last_word_q);
  assign full     = (fill_q == FULL_LVL);
  assign pop      = (state_q == S_IDLE) && (fill_q != '0);
  // A pop frees the slot on the same edge, so a full FIFO still takes the push.
  assign push     = push_req && (!full || pop);
  assign blocked  = push_req && full && !pop;
  assign accept   = (state_q == S_PRESENT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pop) state_d = S_PRESENT;
      S_PRESENT: if (out_ready) state_d = (HOLD_CNT != 4'd0) ? S_HOLD : S_IDLE;
      S_HOLD:    if (hold_cnt_q <= 4'd1) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_PRESENT);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    last_word_d = last_word_q;
    out_word_d  = out_word_q;
    applied_d   = applied_q;
    hold_cnt_d  = hold_cnt_q;
    if (push) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      last_word_d = ctrl_in;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      out_word_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    if (accept) begin
      applied_d  = out_word_q;
      hold_cnt_d = HOLD_CNT;
    end else if (state_q == S_HOLD && hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
    ovf_d = blocked ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      last_word_q <= 8'h00;
      out_word_q  <= 8'h00;
      applied_q   <= 8'h00;
      hold_cnt_q  <= 4'd0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      last_word_q <= last_word_d;
      out_word_q  <= out_word_d;
      applied_q   <= applied_d;
      hold_cnt_q  <= hold_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and fill.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ctrl_in;
  end

  assign out_word     = out_word_q;
  assign applied_word = applied_q;
  assign fill         = fill_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/ctrl_dispatch.md
CTRL_DISPATCH -- requirements
Module: ctrl_dispatch

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 Parameter HOLD, default 3: minimum idle cycles after each dispatched word; 0..15.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ctrl_in  input  8  decoded control word from the upstream control unit; bit i = CTRLi.
REQ-007 ctrl_valid  input  1  ctrl_in is valid this cycle.
REQ-008 out_ready  input  1  downstream datapath accepts out_word.
REQ-009 clear_ovf  input  1  clears the overflow flag.
REQ-010 out_valid  output  1  out_word is offered.
REQ-011 out_word  output  8  control word offered downstream.
REQ-012 applied_word  output  8  last word accepted downstream.
REQ-013 fill  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky: a word change was blocked by a full FIFO.

Function
REQ-015 Change detect: register last_word; a push is requested when ctrl_valid=1 and ctrl_in != last_word.
REQ-016 A requested push with FIFO not full writes ctrl_in and updates last_word to ctrl_in on the same edge.
REQ-017 A requested push with FIFO full shall not write or update last_word; overflow is set, and the same change is re-requested on every following cycle until space frees.
REQ-018 A pop and a push on the same edge shall both occur; fill is unchanged, including when full.
REQ-019 FIFO pointers wrap modulo DEPTH; fill ranges 0..DEPTH; order is strictly first-in first-out.
REQ-020 FSM states: IDLE, PRESENT, HOLD.
REQ-021 IDLE: if fill>0, pop the head into out_word and go to PRESENT; else stay.
REQ-022 PRESENT: out_valid=1, out_word stable; on out_valid&&out_ready, load applied_word=out_word and go to HOLD (HOLD>0) or IDLE (HOLD=0).
REQ-023 HOLD: out_valid=0 for exactly HOLD cycles via a down-counter, then go to IDLE.
REQ-024 out_valid is 1 only in PRESENT; out_word holds its last value elsewhere.
REQ-025 Latency: change sampled at edge N into an empty FIFO with FSM in IDLE -> out_valid=1 after edge N+1.
REQ-026 Dispatch period with out_ready tied high: 2+HOLD cycles per word.
REQ-027 overflow: set takes priority over clear_ovf in the same cycle; otherwise clear_ovf=1 clears it on the next edge.

Reset
REQ-028 rst_n=0 shall immediately force: state=IDLE, out_valid=0, out_word=8'h00, applied_word=8'h00, last_word=8'h00, fill=0, pointers=0, hold counter=0, overflow=0.
REQ-029 Reset mid-PRESENT or mid-HOLD discards the FIFO contents and the offered word; no handshake completes on the reset edge.
REQ-030 After rst_n rises, the first ctrl_in != 8'h00 with ctrl_valid=1 is pushed; ctrl_in=8'h00 is not pushed.

Verification
REQ-031 Reset, then ctrl_in=8'hED, ctrl_valid=1, out_ready=1 -> out_valid=1 with out_word=8'hED two edges after the sample; applied_word=8'hED; out_valid=0 for 3 cycles.
REQ-032 Hold ctrl_in=8'hED for 20 cycles with ctrl_valid=1 -> exactly one dispatch; fill returns to 0.
REQ-033 out_ready=0; apply 8'h01,8'h02,8'h03,8'h04,8'h05,8'h06 on consecutive cycles -> fill caps at 4 (IDLE pop takes 8'h01, then 02..05 fill the FIFO), overflow=1; after releasing out_ready, dispatch order 01,02,03,04,05 and then 06 (re-requested).
REQ-034 Full FIFO, push and pop on the same edge -> fill stays 4, no overflow set that cycle.
REQ-035 overflow=1, clear_ovf=1 in the same cycle as a blocked push -> overflow stays 1; the next clear_ovf with no block -> 0.
REQ-036 Assert rst_n=0 asynchronously during PRESENT with out_word=8'h4F -> out_valid=0 and out_word=8'h00 before the next clock edge; no further dispatch of 8'h4F.
